// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS test core memory subsystem.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and RAM-side signals of the shared memory arbiter.
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) ();

  logic                 i_req;
  logic [ADDR_BITS-1:0] i_addr;
  logic [WORD_W-1:0]    i_rdata;
  logic                 i_ack;

  logic                 d_req;
  logic                 d_we;
  logic [ADDR_BITS-1:0] d_addr;
  logic [WORD_W-1:0]    d_wdata;
  logic [WORD_W-1:0]    d_rdata;
  logic                 d_ack;

  logic                 mem_wr_en;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WORD_W-1:0]    mem_wdata;
  logic [WORD_W-1:0]    mem_rdata;
  logic                 mem_rd_ack;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ack,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    output mem_wr_en, mem_addr, mem_wdata,
    input  mem_rdata, mem_rd_ack
  );

  // Core requesters and RAM side.
  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ack,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  mem_wr_en, mem_addr, mem_wdata,
    output mem_rdata, mem_rd_ack
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational 2-way pick between the fetch and load/store ports.
module arb2_pick
  import mips_mem_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |eligible;
    grant_id    = PORT_I;
    case (eligible)
      2'b01:   grant_id = PORT_I;
      2'b10:   grant_id = PORT_D;
      // Tie: fixed data priority, or alternate away from the previous winner.
      2'b11:   grant_id = DATA_PRIORITY ? PORT_D : ~last_grant;
      default: grant_id = PORT_I;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto one single-port synchronous RAM,
// returning registered read data with a one-cycle ack per requester.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS     = 10,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  state_t               state_q, state_d;
  logic                 port_q, port_d;
  logic                 we_q, we_d;
  logic                 last_grant_q, last_grant_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [WORD_W-1:0]    i_rdata_q, i_rdata_d;
  logic [WORD_W-1:0]    d_rdata_q, d_rdata_d;

  logic [1:0]           eligible;
  logic                 grant_valid;
  logic                 grant_id;

  // A port whose ack is still high has already been served for this request.
  assign eligible[PORT_I] = bus.i_req & ~i_ack_q;
  assign eligible[PORT_D] = bus.d_req & ~d_ack_q;

  arb2_pick #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    mem_wr_en_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          port_d       = grant_id;
          last_grant_d = grant_id;
          state_d      = ISSUE;
          // The RAM-facing registers double as the request latch.
          if (grant_id == PORT_D) begin
            we_d        = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_wr_en_d = bus.d_we;
          end else begin
            we_d        = 1'b0;
            mem_addr_d  = bus.i_addr;
          end
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (bus.mem_rd_ack) begin
          state_d = IDLE;
          if (port_q == PORT_D) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = bus.mem_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      port_q       <= PORT_I;
      we_q         <= 1'b0;
      last_grant_q <= PORT_D;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one data-priority and one round-robin instance,
// each wired to its own behavioural single-port RAM.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_port_arbiter_if #(.ADDR_BITS(10)) bus1 ();
  mem_port_arbiter_if #(.ADDR_BITS(10)) bus0 ();

  mem_port_arbiter #(.ADDR_BITS(10), .DATA_PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );
  mem_port_arbiter #(.ADDR_BITS(10), .DATA_PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  // RAM models with a side preload port owned by the stimulus process.
  logic [31:0] ram1 [0:1023];
  logic [31:0] ram0 [0:1023];
  logic [31:0] rdata1, rdata0;
  logic        rd_ack1 = 1'b1;
  logic        rd_ack0 = 1'b1;
  logic        pre_en = 1'b0, pre_sel = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign bus1.mem_rdata  = rdata1;
  assign bus1.mem_rd_ack = rd_ack1;
  assign bus0.mem_rdata  = rdata0;
  assign bus0.mem_rd_ack = rd_ack0;

  always @(posedge clk) begin
    if (pre_en && !pre_sel) ram1[pre_addr] <= pre_data;
    else if (bus1.mem_wr_en) ram1[bus1.mem_addr] <= bus1.mem_wdata;
    rdata1 <= ram1[bus1.mem_addr];
  end

  always @(posedge clk) begin
    if (pre_en && pre_sel) ram0[pre_addr] <= pre_data;
    else if (bus0.mem_wr_en) ram0[bus0.mem_addr] <= bus0.mem_wdata;
    rdata0 <= ram0[bus0.mem_addr];
  end

  task automatic preload(input logic sel, input logic [9:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_sel = sel; pre_addr = a; pre_data = v; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Bounded load on the data-priority instance; no checking here.
  task automatic d_load1(input logic [9:0] a, output logic [31:0] data, output logic got);
    @(negedge clk);
    bus1.d_addr = a; bus1.d_we = 1'b0; bus1.d_req = 1'b1;
    got = 1'b0; data = '0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus1.d_ack) begin got = 1'b1; data = bus1.d_rdata; end
    end
    bus1.d_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_cnt++; if (bus1.i_ack !== 1'b0) $display("FAIL reset_i_ack: got %0h want 0", bus1.i_ack); else pass_cnt++;
    total_cnt++; if (bus1.d_ack !== 1'b0) $display("FAIL reset_d_ack: got %0h want 0", bus1.d_ack); else pass_cnt++;
    total_cnt++; if (bus1.mem_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0h want 0", bus1.mem_wr_en); else pass_cnt++;
    total_cnt++; if (bus1.mem_addr !== 10'h0) $display("FAIL reset_mem_addr: got %0h want 0", bus1.mem_addr); else pass_cnt++;
    total_cnt++; if (bus1.mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %0h want 0", bus1.mem_wdata); else pass_cnt++;
    total_cnt++; if (bus1.i_rdata !== 32'h0) $display("FAIL reset_i_rdata: got %0h want 0", bus1.i_rdata); else pass_cnt++;
    total_cnt++; if (bus1.d_rdata !== 32'h0) $display("FAIL reset_d_rdata: got %0h want 0", bus1.d_rdata); else pass_cnt++;
    total_cnt++; if (bus0.i_ack !== 1'b0 || bus0.d_ack !== 1'b0) $display("FAIL reset_rr_acks: got %0h%0h want 00", bus0.i_ack, bus0.d_ack); else pass_cnt++;
    rst = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_fetch();
    logic wr_seen, d_seen, ack_bad;
    preload(1'b0, 10'h004, 32'h8C020010);
    @(negedge clk);
    bus1.i_addr = 10'h004; bus1.i_req = 1'b1;
    wr_seen = 1'b0; d_seen = 1'b0; ack_bad = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus1.mem_wr_en) wr_seen = 1'b1;
      if (bus1.d_ack) d_seen = 1'b1;
      if (bus1.i_ack !== (k == 3)) ack_bad = 1'b1;
      if (k == 1) begin
        total_cnt++; if (bus1.mem_addr !== 10'h004) $display("FAIL fetch_mem_addr: got %0h want 004", bus1.mem_addr); else pass_cnt++;
      end
      if (k == 3) begin
        total_cnt++; if (bus1.i_rdata !== 32'h8C020010) $display("FAIL fetch_rdata: got %08h want 8c020010", bus1.i_rdata); else pass_cnt++;
        bus1.i_req = 1'b0;
      end
    end
    total_cnt++; if (wr_seen !== 1'b0) $display("FAIL fetch_no_write: got %0h want 0", wr_seen); else pass_cnt++;
    total_cnt++; if (d_seen !== 1'b0) $display("FAIL fetch_no_d_ack: got %0h want 0", d_seen); else pass_cnt++;
    total_cnt++; if (ack_bad !== 1'b0) $display("FAIL fetch_ack_timing: got %0h want 0", ack_bad); else pass_cnt++;
    $display("fetch: addr=004 rdata=%08h", bus1.i_rdata);
  endtask

  task automatic test_store();
    int          wr_cnt;
    logic        ack_bad, got;
    logic [31:0] data;
    @(negedge clk);
    bus1.d_addr = 10'h3FF; bus1.d_we = 1'b1; bus1.d_wdata = 32'hDEADBEEF; bus1.d_req = 1'b1;
    wr_cnt = 0; ack_bad = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (bus1.mem_wr_en) wr_cnt++;
      if (bus1.d_ack !== (k == 3)) ack_bad = 1'b1;
      if (k == 1) begin
        total_cnt++; if (bus1.mem_addr !== 10'h3FF) $display("FAIL store_mem_addr: got %0h want 3ff", bus1.mem_addr); else pass_cnt++;
        total_cnt++; if (bus1.mem_wdata !== 32'hDEADBEEF) $display("FAIL store_mem_wdata: got %08h want deadbeef", bus1.mem_wdata); else pass_cnt++;
        bus1.d_wdata = 32'h0; bus1.d_addr = 10'h000;
      end
      if (k == 3) begin
        total_cnt++; if (bus1.d_rdata !== 32'h0) $display("FAIL store_rdata_kept: got %08h want 0", bus1.d_rdata); else pass_cnt++;
        bus1.d_req = 1'b0; bus1.d_we = 1'b0;
      end
    end
    total_cnt++; if (wr_cnt !== 1) $display("FAIL store_wr_cycles: got %0d want 1", wr_cnt); else pass_cnt++;
    total_cnt++; if (ack_bad !== 1'b0) $display("FAIL store_ack_timing: got %0h want 0", ack_bad); else pass_cnt++;
    $display("store: addr=3ff data=deadbeef wr_cycles=%0d", wr_cnt);
    d_load1(10'h3FF, data, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL load3ff_ack: got %0h want 1", got); else pass_cnt++;
    total_cnt++; if (data !== 32'hDEADBEEF) $display("FAIL load3ff_data: got %08h want deadbeef", data); else pass_cnt++;
    $display("load: addr=3ff data=%08h", data);
  endtask

  task automatic test_dp_priority();
    logic i_bad, d_bad;
    preload(1'b0, 10'h010, 32'hA1A1A1A1);
    preload(1'b0, 10'h020, 32'hB2B2B2B2);
    @(negedge clk);
    bus1.i_addr = 10'h010; bus1.i_req = 1'b1;
    bus1.d_addr = 10'h020; bus1.d_we = 1'b0; bus1.d_req = 1'b1;
    i_bad = 1'b0; d_bad = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus1.d_ack !== (k == 3)) d_bad = 1'b1;
      if (bus1.i_ack !== (k == 6)) i_bad = 1'b1;
      if (k == 1) bus1.d_addr = 10'h099;
      if (k == 3) begin
        total_cnt++; if (bus1.d_rdata !== 32'hB2B2B2B2) $display("FAIL prio_d_rdata: got %08h want b2b2b2b2", bus1.d_rdata); else pass_cnt++;
        bus1.d_req = 1'b0;
      end
      if (k == 4) begin
        total_cnt++; if (bus1.mem_addr !== 10'h010) $display("FAIL prio_i_back_to_back: got %0h want 010", bus1.mem_addr); else pass_cnt++;
      end
      if (k == 6) begin
        total_cnt++; if (bus1.i_rdata !== 32'hA1A1A1A1) $display("FAIL prio_i_rdata: got %08h want a1a1a1a1", bus1.i_rdata); else pass_cnt++;
        bus1.i_req = 1'b0;
      end
    end
    total_cnt++; if (d_bad !== 1'b0) $display("FAIL prio_d_ack_timing: got %0h want 0", d_bad); else pass_cnt++;
    total_cnt++; if (i_bad !== 1'b0) $display("FAIL prio_i_ack_timing: got %0h want 0", i_bad); else pass_cnt++;
    $display("priority: d_rdata=%08h i_rdata=%08h", bus1.d_rdata, bus1.i_rdata);
  endtask

  task automatic test_round_robin();
    int         n_acks;
    logic [3:0] order;
    logic       both, rd_bad, tim_bad;
    apply_reset();
    preload(1'b1, 10'h030, 32'hC3C3C3C3);
    preload(1'b1, 10'h040, 32'hD4D4D4D4);
    @(negedge clk);
    bus0.i_addr = 10'h030; bus0.i_req = 1'b1;
    bus0.d_addr = 10'h040; bus0.d_we = 1'b0; bus0.d_req = 1'b1;
    n_acks = 0; order = '0; both = 1'b0; rd_bad = 1'b0; tim_bad = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus0.i_ack && bus0.d_ack) both = 1'b1;
      if ((bus0.i_ack | bus0.d_ack) !== (k % 3 == 0)) tim_bad = 1'b1;
      if (bus0.i_ack) begin
        if (n_acks < 4) order[n_acks] = PORT_I;
        n_acks++;
        if (bus0.i_rdata !== 32'hC3C3C3C3) rd_bad = 1'b1;
      end
      if (bus0.d_ack) begin
        if (n_acks < 4) order[n_acks] = PORT_D;
        n_acks++;
        if (bus0.d_rdata !== 32'hD4D4D4D4) rd_bad = 1'b1;
      end
    end
    bus0.i_req = 1'b0; bus0.d_req = 1'b0;
    total_cnt++; if (n_acks !== 4) $display("FAIL rr_ack_count: got %0d want 4", n_acks); else pass_cnt++;
    total_cnt++; if (order !== 4'b1010) $display("FAIL rr_order: got %b want 1010 (bit0 first, 0=I 1=D)", order); else pass_cnt++;
    total_cnt++; if (both !== 1'b0) $display("FAIL rr_dual_ack: got %0h want 0", both); else pass_cnt++;
    total_cnt++; if (tim_bad !== 1'b0) $display("FAIL rr_ack_timing: got %0h want 0", tim_bad); else pass_cnt++;
    total_cnt++; if (rd_bad !== 1'b0) $display("FAIL rr_rdata: got %0h want 0", rd_bad); else pass_cnt++;
    $display("round_robin: acks=%0d order=%b", n_acks, order);
  endtask

  task automatic test_stall();
    logic bad;
    @(negedge clk);
    rst = 1'b1; rd_ack1 = 1'b0;
    bus1.i_addr = 10'h004; bus1.i_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 5 && bus1.i_ack !== 1'b0) bad = 1'b1;
      if (k == 5) rd_ack1 = 1'b1;
      if (k == 6) begin
        total_cnt++; if (bus1.i_ack !== 1'b1) $display("FAIL stall_ack: got %0h want 1", bus1.i_ack); else pass_cnt++;
        total_cnt++; if (bus1.i_rdata !== 32'h8C020010) $display("FAIL stall_rdata: got %08h want 8c020010", bus1.i_rdata); else pass_cnt++;
        bus1.i_req = 1'b0;
      end
      if (k == 7) begin
        total_cnt++; if (bus1.i_ack !== 1'b0) $display("FAIL stall_ack_single: got %0h want 0", bus1.i_ack); else pass_cnt++;
      end
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL stall_early_ack: got %0h want 0", bad); else pass_cnt++;
    $display("stall: i_rdata=%08h", bus1.i_rdata);
  endtask

  task automatic test_reset_store();
    logic        ack_seen, got;
    logic [31:0] data;
    preload(1'b0, 10'h050, 32'h11111111);
    @(negedge clk);
    bus1.d_addr = 10'h050; bus1.d_we = 1'b1; bus1.d_wdata = 32'h22222222; bus1.d_req = 1'b1;
    @(posedge clk);
    #2;
    total_cnt++; if (bus1.mem_wr_en !== 1'b1) $display("FAIL rststore_issue: got %0h want 1", bus1.mem_wr_en); else pass_cnt++;
    rst = 1'b1;
    bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    #1;
    total_cnt++; if (bus1.mem_wr_en !== 1'b0) $display("FAIL rststore_wr_drop: got %0h want 0", bus1.mem_wr_en); else pass_cnt++;
    ack_seen = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (bus1.d_ack) ack_seen = 1'b1;
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus1.d_ack) ack_seen = 1'b1;
    end
    total_cnt++; if (ack_seen !== 1'b0) $display("FAIL rststore_no_ack: got %0h want 0", ack_seen); else pass_cnt++;
    d_load1(10'h050, data, got);
    total_cnt++; if (got !== 1'b1) $display("FAIL rststore_load_ack: got %0h want 1", got); else pass_cnt++;
    total_cnt++; if (data !== 32'h11111111) $display("FAIL rststore_data: got %08h want 11111111", data); else pass_cnt++;
    $display("reset_store: addr=050 data=%08h", data);
  endtask

  initial begin
    bus1.i_req = 1'b0; bus1.i_addr = '0;
    bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus0.i_req = 1'b0; bus0.i_addr = '0;
    bus0.d_req = 1'b0; bus0.d_we = 1'b0; bus0.d_addr = '0; bus0.d_wdata = '0;
    test_reset();
    test_fetch();
    test_store();
    test_dp_priority();
    test_round_robin();
    test_stall();
    test_reset_store();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
